// File: rtl/kmeans_pkg.sv
// Shared state encoding and default widths for the k-means sequencer.
// Encoding is visible on the state port, so the values are fixed.
package kmeans_pkg;

  localparam int PIX_W  = 24;
  localparam int SIZE_W = 12;

  typedef enum logic [2:0] {
    S_CONFIG  = 3'b000,
    S_LOAD    = 3'b001,
    S_CLUSTER = 3'b010,
    S_SUM     = 3'b011,
    S_DIVIDE  = 3'b100,
    S_UPDATE  = 3'b101,
    S_DONE    = 3'b110,
    S_IDLE    = 3'b111
  } state_t;

endpackage

// File: rtl/kmeans_seq_ctrl.sv
// Sequencer for the k-means datapath: config latch, pixel intake, iteration loop, status.
// Pixel path is combinational pass-through; only control and counters are registered.
module kmeans_seq_ctrl #(
  parameter int K      = 16,
  parameter int PIX_W  = kmeans_pkg::PIX_W,
  parameter int SIZE_W = kmeans_pkg::SIZE_W,
  parameter int ITER_W = 6
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [SIZE_W-1:0] cfg_image_size,
  input  logic [K-1:0]      cfg_enable,
  input  logic [ITER_W-1:0] cfg_max_iter,
  input  logic              pix_valid,
  input  logic [PIX_W-1:0]  pix_data,
  output logic              pix_ready,
  output logic              eng_valid,
  output logic [PIX_W-1:0]  eng_pixel,
  output logic              eng_end_of_image,
  input  logic              eng_done,
  input  logic              sum_done_all,
  input  logic              div_ready_all,
  input  logic              mean_stable,
  output logic              mean_load,
  output logic [K-1:0]      enabled,
  output logic [ITER_W-1:0] iter_count,
  output logic [2:0]        state,
  output logic              strb,
  output logic              converged,
  output logic              timeout,
  output logic              cfg_err
);
  import kmeans_pkg::*;

  state_t            state_q, state_nxt;
  logic [SIZE_W-1:0] size_r, pix_cnt;
  logic [ITER_W-1:0] max_r;
  logic              cfg_bad, accept, last_beat, cap_hit;

  assign cfg_bad   = (cfg_image_size == '0) || (cfg_enable == '0);
  assign accept    = pix_valid & pix_ready;
  assign last_beat = (pix_cnt == size_r - SIZE_W'(1));
  // max_r of 0 wraps to all-ones here, giving a cap of 2^ITER_W iterations.
  assign cap_hit   = (iter_count == max_r - ITER_W'(1));

  assign state            = state_q;
  assign pix_ready        = (state_q == S_LOAD) && !abort;
  assign eng_valid        = accept;
  assign eng_pixel        = pix_data;
  assign eng_end_of_image = (state_q == S_CLUSTER);
  assign mean_load        = (state_q == S_UPDATE) && !abort;
  assign strb             = (state_q == S_DONE);

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      S_IDLE:    if (start) state_nxt = S_CONFIG;
      S_CONFIG:  state_nxt = cfg_bad ? S_DONE : S_LOAD;
      S_LOAD:    if (accept && last_beat) state_nxt = S_CLUSTER;
      S_CLUSTER: if (eng_done) state_nxt = S_SUM;
      S_SUM:     if (sum_done_all) state_nxt = S_DIVIDE;
      S_DIVIDE:  if (div_ready_all) state_nxt = (mean_stable || cap_hit) ? S_DONE : S_UPDATE;
      S_UPDATE:  state_nxt = S_CLUSTER;
      S_DONE:    if (start) state_nxt = S_CONFIG;
      default:   state_nxt = S_IDLE;
    endcase
    if (abort) state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      size_r     <= '0;
      max_r      <= '0;
      pix_cnt    <= '0;
      enabled    <= '0;
      iter_count <= '0;
      converged  <= 1'b0;
      timeout    <= 1'b0;
      cfg_err    <= 1'b0;
    end else if (abort) begin
      // enabled and iter_count stay visible after an abort for debug.
      converged <= 1'b0;
      timeout   <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      case (state_q)
        S_CONFIG: begin
          size_r     <= cfg_image_size;
          max_r      <= cfg_max_iter;
          pix_cnt    <= '0;
          iter_count <= '0;
          converged  <= 1'b0;
          timeout    <= 1'b0;
          cfg_err    <= cfg_bad;
          enabled    <= cfg_bad ? '0 : cfg_enable;
        end
        S_LOAD:   if (accept) pix_cnt <= pix_cnt + SIZE_W'(1);
        S_DIVIDE: begin
          if (div_ready_all) begin
            if (mean_stable)  converged <= 1'b1;
            else if (cap_hit) timeout   <= 1'b1;
          end
        end
        S_UPDATE: iter_count <= iter_count + ITER_W'(1);
        default: ;
      endcase
    end
  end

endmodule
